// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-ported data memory between the MEM stage
//               (single word, priority) and a burst master with bounded wait.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_memRead,
  input  logic        p0_memWrite,
  input  logic [31:0] p0_address,
  input  logic [31:0] p0_writedata,
  output logic [31:0] p0_readdata,
  output logic        p0_stall,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_address,
  input  logic [3:0]  p1_len,
  input  logic [31:0] p1_writedata,
  output logic [31:0] p1_readdata,
  output logic        p1_ack,
  output logic        p1_done,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_readdata
);

  localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  wait_q, wait_d;
  logic        we_q, we_d;
  logic [31:0] base_q, base_d;

  logic        w_p0_req;
  logic        w_grant;
  logic        w_last;
  logic [31:0] w_burst_addr;

  assign w_p0_req     = p0_memRead || p0_memWrite;
  assign w_grant      = (state_q == IDLE) && p1_req && (!w_p0_req || (wait_q == C_MAX_WAIT));
  assign w_last       = (beat_q == len_q);
  assign w_burst_addr = base_q + {26'd0, beat_q, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= 4'd0;
      len_q   <= 4'd0;
      wait_q  <= 4'd0;
      we_q    <= 1'b0;
      base_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    len_d         = len_q;
    wait_d        = wait_q;
    we_d          = we_q;
    base_d        = base_q;
    mem_address   = p0_address;
    mem_writedata = p0_writedata;
    mem_memRead   = p0_memRead;
    mem_memWrite  = p0_memWrite;
    p0_readdata   = mem_readdata;
    p0_stall      = 1'b0;
    p1_readdata   = 32'd0;
    p1_ack        = 1'b0;
    p1_done       = 1'b0;

    case (state_q)
      IDLE: begin
        // The port 0 access of the grant cycle still goes through above.
        if (w_grant) begin
          state_d = BURST;
          base_d  = p1_address;
          len_d   = p1_len;
          we_d    = p1_we;
          beat_d  = 4'd0;
          wait_d  = 4'd0;
        end else if (!p1_req) begin
          wait_d = 4'd0;
        end else if (w_p0_req && (wait_q != C_MAX_WAIT)) begin
          wait_d = wait_q + 4'd1;
        end
      end
      BURST: begin
        mem_address   = w_burst_addr;
        mem_writedata = p1_writedata;
        mem_memWrite  = we_q;
        mem_memRead   = !we_q;
        p0_readdata   = 32'd0;
        p0_stall      = w_p0_req;
        p1_readdata   = we_q ? 32'd0 : mem_readdata;
        p1_ack        = 1'b1;
        p1_done       = w_last;
        if (w_last) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench: directed table, corner sequences and
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int C_MAX_WAIT = 8;

  logic        clk;
  logic        rst;
  logic        p0_memRead, p0_memWrite;
  logic [31:0] p0_address, p0_writedata, p0_readdata;
  logic        p0_stall;
  logic        p1_req, p1_we;
  logic [31:0] p1_address;
  logic [3:0]  p1_len;
  logic [31:0] p1_writedata, p1_readdata;
  logic        p1_ack, p1_done;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_memRead, mem_memWrite;

  dmem_arbiter #(.MAX_WAIT(C_MAX_WAIT)) u_dut (
    .clk(clk), .rst(rst),
    .p0_memRead(p0_memRead), .p0_memWrite(p0_memWrite),
    .p0_address(p0_address), .p0_writedata(p0_writedata),
    .p0_readdata(p0_readdata), .p0_stall(p0_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_address(p1_address), .p1_len(p1_len),
    .p1_writedata(p1_writedata), .p1_readdata(p1_readdata),
    .p1_ack(p1_ack), .p1_done(p1_done),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory stand-in: 256 words, aliased on address[9:2].
  logic [31:0] tbmem [256] = '{default: 32'd0};
  assign mem_readdata = tbmem[mem_address[9:2]];
  always @(posedge clk) if (mem_memWrite) tbmem[mem_address[9:2]] <= mem_writedata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a granted burst becomes a queue of beat addresses.
  logic [31:0] mm [256];
  logic [31:0] q_addr [$];
  logic        q_we;
  int          waitc;

  logic        s_ack, s_done, s_stall, s_mwe;
  logic [31:0] s_p1rd;

  task automatic cycle();
    logic        busy, e_mwe, e_mrd, e_ack, e_done, e_stall, p0req;
    logic [31:0] e_addr, e_wd, e_p0rd, e_p1rd;
    #1;
    if (!rst) begin
      q_addr.delete();
      waitc = 0;
    end
    p0req = p0_memRead || p0_memWrite;
    busy  = (q_addr.size() > 0);
    if (busy) begin
      e_addr  = q_addr[0];
      e_wd    = p1_writedata;
      e_mwe   = q_we;
      e_mrd   = !q_we;
      e_ack   = 1'b1;
      e_done  = (q_addr.size() == 1);
      e_stall = p0req;
      e_p0rd  = 32'd0;
      e_p1rd  = q_we ? 32'd0 : mm[e_addr[9:2]];
    end else begin
      e_addr  = p0_address;
      e_wd    = p0_writedata;
      e_mwe   = p0_memWrite;
      e_mrd   = p0_memRead;
      e_ack   = 1'b0;
      e_done  = 1'b0;
      e_stall = 1'b0;
      e_p0rd  = mm[p0_address[9:2]];
      e_p1rd  = 32'd0;
    end
    chk("mem_address", mem_address, e_addr);
    chk("mem_memWrite", {31'd0, mem_memWrite}, {31'd0, e_mwe});
    chk("mem_memRead", {31'd0, mem_memRead}, {31'd0, e_mrd});
    if (e_mwe) chk("mem_writedata", mem_writedata, e_wd);
    chk("p1_ack", {31'd0, p1_ack}, {31'd0, e_ack});
    chk("p1_done", {31'd0, p1_done}, {31'd0, e_done});
    chk("p0_stall", {31'd0, p0_stall}, {31'd0, e_stall});
    chk("p0_readdata", p0_readdata, e_p0rd);
    chk("p1_readdata", p1_readdata, e_p1rd);
    s_ack = p1_ack; s_done = p1_done; s_stall = p0_stall;
    s_mwe = mem_memWrite; s_p1rd = p1_readdata;
    @(posedge clk);
    if (e_mwe) mm[e_addr[9:2]] = e_wd;
    if (!rst) begin
      waitc = 0;
    end else if (busy) begin
      void'(q_addr.pop_front());
    end else if (p1_req && (!p0req || waitc == C_MAX_WAIT)) begin
      for (int k = 0; k <= int'(p1_len); k++) q_addr.push_back(p1_address + 32'(4 * k));
      q_we  = p1_we;
      waitc = 0;
    end else if (!p1_req) begin
      waitc = 0;
    end else if (p0req && waitc < C_MAX_WAIT) begin
      waitc++;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        p0r, p0w;
    logic [31:0] p0a, p0wd;
    logic        req, we;
    logic [31:0] a;
    logic [3:0]  len;
    logic [31:0] wd;
    logic        e_ack, e_done, e_stall;
    logic [31:0] e_addr;
    logic        e_mwe;
    logic [31:0] e_p1rd, e_p0rd;
  } vec_t;

  vec_t vec [17];

  task automatic drive_idle();
    p0_memRead = 0; p0_memWrite = 0; p0_address = 0; p0_writedata = 0;
    p1_req = 0; p1_we = 0; p1_address = 0; p1_len = 0; p1_writedata = 0;
  endtask

  initial begin
    int first, acks, dones;
    for (int i = 0; i < 256; i++) mm[i] = 32'd0;
    q_we = 1'b0; waitc = 0;
    rst = 1'b0;
    drive_idle();
    p1_req = 1; p1_we = 1; p1_len = 4'd5;
    @(negedge clk);
    cycle();
    chk("reset_ack", {31'd0, s_ack}, 32'd0);
    chk("reset_stall", {31'd0, s_stall}, 32'd0);
    cycle();
    chk("reset_p1rd", s_p1rd, 32'd0);
    rst = 1'b1;
    drive_idle();
    cycle();

    // p0r p0w p0a p0wd | req we a len wd | ack done stall addr mwe p1rd p0rd
    vec[0]  = '{0,0,0,0,            1,1,32'h100,3,0,   0,0,0,32'h0,0,0,0};
    vec[1]  = '{0,0,0,0,            0,0,0,0,1,         1,0,0,32'h100,1,0,0};
    vec[2]  = '{0,0,0,0,            0,0,0,0,2,         1,0,0,32'h104,1,0,0};
    vec[3]  = '{0,0,0,0,            0,0,0,0,3,         1,0,0,32'h108,1,0,0};
    vec[4]  = '{0,0,0,0,            0,0,0,0,4,         1,1,0,32'h10C,1,0,0};
    vec[5]  = '{0,0,0,0,            1,0,32'h100,3,0,   0,0,0,32'h0,0,0,0};
    vec[6]  = '{0,0,0,0,            0,0,0,0,0,         1,0,0,32'h100,0,1,0};
    vec[7]  = '{0,0,0,0,            0,0,0,0,0,         1,0,0,32'h104,0,2,0};
    vec[8]  = '{0,0,0,0,            0,0,0,0,0,         1,0,0,32'h108,0,3,0};
    vec[9]  = '{0,0,0,0,            0,0,0,0,0,         1,1,0,32'h10C,0,4,0};
    vec[10] = '{0,1,32'h40,32'hDEADBEEF, 0,0,0,0,0,   0,0,0,32'h40,1,0,0};
    vec[11] = '{1,0,32'h40,0,       0,0,0,0,0,         0,0,0,32'h40,0,0,32'hDEADBEEF};
    vec[12] = '{0,0,0,0,            1,0,32'hFFFFFFF8,3,0, 0,0,0,32'h0,0,0,0};
    vec[13] = '{0,0,0,0,            0,0,0,0,0,         1,0,0,32'hFFFFFFF8,0,0,0};
    vec[14] = '{1,0,32'h40,0,       0,0,0,0,0,         1,0,1,32'hFFFFFFFC,0,0,0};
    vec[15] = '{0,0,0,0,            0,0,0,0,0,         1,0,0,32'h0,0,0,0};
    vec[16] = '{0,0,0,0,            0,0,0,0,0,         1,1,0,32'h4,0,0,0};

    for (int i = 0; i < 17; i++) begin
      p0_memRead = vec[i].p0r; p0_memWrite = vec[i].p0w;
      p0_address = vec[i].p0a; p0_writedata = vec[i].p0wd;
      p1_req = vec[i].req; p1_we = vec[i].we; p1_address = vec[i].a;
      p1_len = vec[i].len; p1_writedata = vec[i].wd;
      #1;
      chk($sformatf("vec%0d_ack", i), {31'd0, p1_ack}, {31'd0, vec[i].e_ack});
      chk($sformatf("vec%0d_done", i), {31'd0, p1_done}, {31'd0, vec[i].e_done});
      chk($sformatf("vec%0d_stall", i), {31'd0, p0_stall}, {31'd0, vec[i].e_stall});
      chk($sformatf("vec%0d_addr", i), mem_address, vec[i].e_addr);
      chk($sformatf("vec%0d_mwe", i), {31'd0, mem_memWrite}, {31'd0, vec[i].e_mwe});
      chk($sformatf("vec%0d_p1rd", i), p1_readdata, vec[i].e_p1rd);
      chk($sformatf("vec%0d_p0rd", i), p0_readdata, vec[i].e_p0rd);
      cycle();
    end
    drive_idle();
    cycle();

    // Port 0 writes every cycle; port 1 must wait MAX_WAIT refusals.
    p0_memWrite = 1; p0_address = 32'h300;
    p1_req = 1; p1_we = 0; p1_address = 32'h100; p1_len = 4'd1;
    first = -1;
    for (int c = 0; c < 11; c++) begin
      p0_writedata = c;
      cycle();
      if (s_ack) begin
        if (first < 0) first = c;
        p1_req = 0;
        chk("conflict_stall", {31'd0, s_stall}, 32'd1);
        chk("conflict_nowrite", {31'd0, s_mwe}, 32'd0);
      end
    end
    chk("conflict_grant_cycle", first, 32'd9);
    chk("conflict_p0_last_word", tbmem[8'hC0], 32'd8);
    drive_idle();
    cycle();

    // Reset during beat 2 of a 16-word write burst.
    p1_req = 1; p1_we = 1; p1_address = 32'h200; p1_len = 4'd15;
    cycle();
    p1_req = 0;
    p1_writedata = 32'hA0; cycle();
    p1_writedata = 32'hA1; cycle();
    p1_writedata = 32'hA2; rst = 1'b0;
    cycle();
    chk("rst_mid_ack", {31'd0, s_ack}, 32'd0);
    chk("rst_mid_mwe", {31'd0, s_mwe}, 32'd0);
    p1_writedata = 32'hA3; cycle();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("rst_no_resume", {31'd0, s_ack}, 32'd0);
    end
    chk("rst_beat0", tbmem[8'h80], 32'hA0);
    chk("rst_beat1", tbmem[8'h81], 32'hA1);
    for (int w = 8'h82; w <= 8'h8F; w++) chk($sformatf("rst_untouched%0h", w), tbmem[w], 32'd0);

    // Request dropped right after grant: burst still runs all 8 beats.
    p1_req = 1; p1_we = 1; p1_address = 32'h280; p1_len = 4'd7;
    acks = 0; dones = 0;
    for (int c = 0; c < 12; c++) begin
      p1_writedata = 32'h5000 + c;
      cycle();
      p1_req = 0;
      acks += int'(s_ack);
      dones += int'(s_done);
    end
    chk("drop_beats", acks, 32'd8);
    chk("drop_done_pulses", dones, 32'd1);

    // Randomized traffic, every cycle compared against the model.
    drive_idle();
    for (int c = 0; c < 600; c++) begin
      int r;
      r = $urandom_range(0, 9);
      p0_memRead  = (r < 3);
      p0_memWrite = (r >= 3 && r < 6);
      p0_address  = $urandom;
      p0_writedata = $urandom;
      p1_writedata = $urandom;
      if (p1_req && s_ack) p1_req = 0;
      else if (!p1_req && ($urandom_range(0, 3) == 0)) begin
        p1_req = 1;
        p1_we = $urandom_range(0, 1);
        p1_address = $urandom;
        p1_len = 4'($urandom_range(0, 15));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer in front of the single-ported data memory (`dataMem`). It shares the memory between the pipeline MEM stage (port 0, single-word, priority) and a secondary master (port 1, e.g. loader or debug), which issues multi-word bursts. Port 0 is stalled while a burst owns the memory. A wait counter bounds port 1 starvation. The memory interface matches the data memory: combinational read, write on posedge `clk`, word index = address[31:2].

## Interface
- MAX_WAIT, 8: cycles port 1 may be refused while port 0 requests before port 1 is forced in (1..15).

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- p0_memRead  in  1  MEM-stage read request
- p0_memWrite  in  1  MEM-stage write request
- p0_address  in  32  MEM-stage byte address
- p0_writedata  in  32  MEM-stage write data
- p0_readdata  out  32  read data to MEM stage
- p0_stall  out  1  MEM stage must hold its request
- p1_req  in  1  burst request (level; hold until first p1_ack)
- p1_we  in  1  burst direction: 1 write, 0 read (latched at grant)
- p1_address  in  32  burst base byte address (latched at grant)
- p1_len  in  4  beats minus one: 0 = 1 word, 15 = 16 words (latched at grant)
- p1_writedata  in  32  write data for the current beat
- p1_readdata  out  32  read data for the current beat
- p1_ack  out  1  a beat is performed this cycle
- p1_done  out  1  high in the last beat's cycle
- mem_address, mem_writedata  out  32  to data memory
- mem_memRead, mem_memWrite  out  1  to data memory
- mem_readdata  in  32  from data memory

## Operation
- States: IDLE, BURST. Registers: state, beat[3:0], len_q[3:0], we_q, base_q[31:0], wait_cnt[3:0].
- IDLE: the memory is driven combinationally by port 0. mem_* = p0_*, p0_readdata = mem_readdata, p0_stall = 0. p1_ack = 0 and p1_readdata = 0.
- Grant condition in IDLE: p1_req && (!(p0_memRead||p0_memWrite) || wait_cnt == MAX_WAIT).
  - On grant: latch base_q, len_q, we_q. Set beat = 0 and wait_cnt = 0. Go to BURST.
  - The port 0 access in the grant cycle still completes.
- wait_cnt in IDLE:
  - Increments when p1_req and port 0 is requesting and there is no grant.
  - Clears when p1_req = 0.
  - Saturates at MAX_WAIT.
- BURST, each cycle:
  - mem_address = base_q + {beat,2'b00}, 32-bit add, wraps mod 2^32.
  - mem_memWrite = we_q, mem_memRead = !we_q.
  - mem_writedata = p1_writedata.
  - p1_readdata = mem_readdata when !we_q, else 0.
  - p1_ack = 1.
  - p0_stall = p0_memRead || p0_memWrite, and p0_readdata = 0.
- Last beat (beat == len_q): p1_done = 1, next state is IDLE. Otherwise beat increments.
- A burst always runs to completion. Dropping p1_req mid-burst has no effect.
- Back-to-back bursts: p1_req still high in IDLE with port 0 idle grants on that same cycle.
- p0_memRead and p0_memWrite both high: treated as a write (mem_memRead also passes through). Caller must avoid this.

## Timing
- Reset (rst = 0, any time, including mid-burst):
  - state = IDLE, beat = 0, wait_cnt = 0, len_q = 0, we_q = 0, base_q = 0.
  - Outputs follow IDLE: p0_stall = 0, p1_ack = 0, p1_done = 0, p1_readdata = 0.
  - No further burst writes occur. A partial burst is not resumed.
- Port 0 latency: 0 cycles when not stalled. Read data is valid in the request cycle, and a write commits at the next edge.
- Port 1:
  - The grant edge is followed by the first beat in the next cycle.
  - An N-word burst occupies exactly N cycles in BURST.
  - Port 0 is stalled for at most 16 cycles per burst.
- Worst-case port 1 latency with continuous port 0 traffic is MAX_WAIT + 1 cycles to grant.

## Test plan
- Port 0 only: write 0xDEADBEEF to 0x40, next cycle read 0x40 -> p0_readdata = 0xDEADBEEF, p0_stall always 0.
- Burst write: base 0x100, len 3, data 1,2,3,4. Expect grant next edge, then 4 cycles of p1_ack with mem_address 0x100, 0x104, 0x108, 0x10C, and p1_done in the 4th. A burst read back returns 1,2,3,4.
- Conflict: port 0 requests every cycle and p1_req rises with MAX_WAIT = 8 -> grant after 9 cycles. During the burst p0_stall = 1 and no port 0 write reaches memory.
- Wrap: base 0xFFFFFFF8, len 3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Reset asserted at beat 2 of a 16-word write burst -> beats 0–1 written, from the reset edge p1_ack = 0 and mem_memWrite follows port 0, and the remaining words are unchanged.
- p1_req dropped after the grant with len 7 -> all 8 beats still performed, and p1_done pulses once.
